// File: rtl/encript.sv
// Trivium keystream generator, 64 steps per clock, key/IV fixed at elaboration.
// Define ENCRIPT_PLAINTEXT_XOR_EN to XOR PLAINTEXT into every run-phase block.
module encript_step (
    input  logic [287:0] s_in,
    output logic [287:0] s_out,
    output logic         z
);
    // s_in[i-1] holds Trivium state bit s_i
    logic t1, t2, t3;

    always_comb begin
        t1 = s_in[65]  ^ s_in[92];
        t2 = s_in[161] ^ s_in[176];
        t3 = s_in[242] ^ s_in[287];
        z  = t1 ^ t2 ^ t3;
        t1 = t1 ^ (s_in[90]  & s_in[91])  ^ s_in[170];
        t2 = t2 ^ (s_in[174] & s_in[175]) ^ s_in[263];
        t3 = t3 ^ (s_in[285] & s_in[286]) ^ s_in[68];
        s_out = {s_in[286:177], t2, s_in[175:93], t1, s_in[91:0], t3};
    end
endmodule

module encript #(
    parameter logic [79:0] KEY       = 80'h0,
    parameter logic [79:0] IV        = 80'h0,
    parameter logic [63:0] PLAINTEXT = 64'h0
) (
    input  logic        clk,
    input  logic        reset,
    output logic [63:0] OUT
);
    localparam int          NUM_LANES = 64;
    localparam logic [4:0]  INIT_CYC  = 5'd18;

    function automatic logic [287:0] load_state();
        logic [287:0] v;
        v = '0;
        for (int i = 0; i < 80; i++) begin
            v[i]      = KEY[79-i];
            v[93 + i] = IV[79-i];
        end
        v[287:285] = 3'b111;
        return v;
    endfunction

    localparam logic [287:0] ST_INIT = load_state();

`ifdef ENCRIPT_PLAINTEXT_XOR_EN
    localparam logic [63:0] OUT_MASK = PLAINTEXT;
`else
    localparam logic [63:0] OUT_MASK = PLAINTEXT & 64'h0;
`endif

    logic [287:0]                  st;
    logic [4:0]                    cnt;
    logic [NUM_LANES:0][287:0]     chain;
    logic [NUM_LANES-1:0]          ks;

    assign chain[0] = st;

    // lane i performs step i+1; its z bit lands MSB-first
    for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
        encript_step u_step (
            .s_in  (chain[i]),
            .s_out (chain[i+1]),
            .z     (ks[NUM_LANES-1-i])
        );
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            st  <= ST_INIT;
            cnt <= '0;
            OUT <= '0;
        end else begin
            st <= chain[NUM_LANES];
            if (cnt < INIT_CYC) begin
                cnt <= cnt + 5'd1;
                OUT <= '0;
            end else begin
                OUT <= ks ^ OUT_MASK;
            end
        end
    end
endmodule

// File: tb/tb_encript.sv
// Scoreboard bench for encript: three key/IV configurations against a bit-serial Trivium model.
module tb_encript;
    localparam logic [79:0] K0 = 80'h0;
    localparam logic [79:0] V0 = 80'h0;
    localparam logic [79:0] K1 = 80'h80000000000000000000;
    localparam logic [79:0] V1 = 80'h0;
    localparam logic [79:0] K2 = 80'h0123456789abcdef0123;
    localparam logic [79:0] V2 = 80'hfedcba9876543210a5c3;
    localparam logic [63:0] PT = 64'hffff_ffff_ffff_ffff;
    localparam int NB = 64;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [63:0] out0, out1, out2;

    always #5 clk = ~clk;

    encript #(.KEY(K0), .IV(V0), .PLAINTEXT(PT)) dut0 (.clk(clk), .reset(reset), .OUT(out0));
    encript #(.KEY(K1), .IV(V1), .PLAINTEXT(PT)) dut1 (.clk(clk), .reset(reset), .OUT(out1));
    encript #(.KEY(K2), .IV(V2), .PLAINTEXT(PT)) dut2 (.clk(clk), .reset(reset), .OUT(out2));

    logic [63:0] ks [3][NB];

    typedef struct {
        logic [63:0] e [3];
        int          n;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   failures = 0;
    bit   started = 0;
    bit   done = 0;
    int   n = 0;

    // Straight bit-serial Trivium with 1-based state, packing blocks MSB-first.
    task automatic gen(input int d, input logic [79:0] k, input logic [79:0] iv);
        bit s [1:288];
        bit t1, t2, t3, z;
        int r;
        for (int i = 1; i <= 288; i++) s[i] = 0;
        for (int i = 1; i <= 80; i++) begin
            s[i]      = k[80-i];
            s[93 + i] = iv[80-i];
        end
        s[286] = 1; s[287] = 1; s[288] = 1;
        for (int t = 0; t < 1152 + 64 * NB; t++) begin
            t1 = s[66] ^ s[93];
            t2 = s[162] ^ s[177];
            t3 = s[243] ^ s[288];
            z  = t1 ^ t2 ^ t3;
            t1 = t1 ^ (s[91] & s[92]) ^ s[171];
            t2 = t2 ^ (s[175] & s[176]) ^ s[264];
            t3 = t3 ^ (s[286] & s[287]) ^ s[69];
            for (int j = 93; j >= 2; j--)   s[j] = s[j-1];
            s[1] = t3;
            for (int j = 177; j >= 95; j--) s[j] = s[j-1];
            s[94] = t1;
            for (int j = 288; j >= 179; j--) s[j] = s[j-1];
            s[178] = t2;
            if (t >= 1152) begin
                r = t - 1152;
                ks[d][r / 64][63 - (r % 64)] = z;
            end
        end
    endtask

    // One clock: drive reset, then predict OUT after the coming rising edge.
    task automatic cyc(input bit r);
        exp_t x;
        @(negedge clk);
        reset = r;
        if (r) n = 0;
        else   n = n + 1;
        for (int d = 0; d < 3; d++) begin
            if (!r && n >= 19 && n - 19 < NB) begin
`ifdef ENCRIPT_PLAINTEXT_XOR_EN
                x.e[d] = ks[d][n-19] ^ PT;
`else
                x.e[d] = ks[d][n-19];
`endif
            end else begin
                x.e[d] = 64'h0;
            end
        end
        x.n = r ? -1 : n;
        q.push_back(x);
        started = 1;
    endtask

    task automatic run(input int nrst, input int nrun);
        for (int i = 0; i < nrst; i++) cyc(1'b1);
        for (int i = 0; i < nrun; i++) cyc(1'b0);
    endtask

    // Monitor: every rising edge produces one OUT sample per DUT.
    initial begin
        exp_t x;
        logic [63:0] act;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() == 0) begin
                if (started && !done) begin
                    checks++;
                    failures++;
                    $display("FAIL scoreboard_empty t=%0t", $time);
                end
            end else begin
                x = q.pop_front();
                for (int d = 0; d < 3; d++) begin
                    act = (d == 0) ? out0 : (d == 1) ? out1 : out2;
                    checks++;
                    if (act !== x.e[d]) begin
                        failures++;
                        $display("FAIL out dut%0d edge=%0d got=%h exp=%h", d, x.n, act, x.e[d]);
                    end
                end
            end
        end
    end

    initial begin
        int nr, nl;
        gen(0, K0, V0);
        gen(1, K1, V1);
        gen(2, K2, V2);
        // initial reset held 2 cycles, then 50 free-running cycles
        run(2, 50);
        // 1-cycle reset in run phase, sequence must restart from block 0
        run(1, 25);
        // reset mid-init, then a full restart
        run(1, 10);
        run(1, 25);
        // randomized reset lengths and release windows
        for (int i = 0; i < 6; i++) begin
            nr = $urandom_range(1, 3);
            nl = $urandom_range(1, 40);
            run(nr, nl);
        end
        @(posedge clk);
        #2;
        done = 1;
        if (q.size() != 0) begin
            checks++;
            failures++;
            $display("FAIL scoreboard_leftover got=%0d exp=0", q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/encript.md
Name: encript

Overview:
- Trivium stream-cipher keystream generator, unrolled to 64 Trivium steps per clock.
- Key and IV are fixed at elaboration time; no runtime key or IV loading.
- After reset it runs the 1152-step initialisation internally, then emits one 64-bit keystream block every cycle on OUT.
- Free-running leaf block; a downstream consumer XORs or packs the blocks.

Parameters:
- KEY, 80'h0, 80-bit secret key; KEY[79] is Trivium K1.
- IV, 80'h0, 80-bit initialisation vector; IV[79] is Trivium IV1.
- PLAINTEXT, 64'h0, constant data word used only with the optional feature.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- OUT  output  64  registered keystream block (ciphertext with the optional feature).

Behaviour:
- Interface: one clock (clk); reset is synchronous and active-high.
- State: 288-bit register s1..s288, a 5-bit init counter cnt, and a 64-bit OUT register.
- Reset (rising edge with reset=1):
  - s1..s80 = K1..K80; s81..s93 = 0.
  - s94..s173 = IV1..IV80; s174..s177 = 0.
  - s178..s285 = 0; s286..s288 = 1.
  - cnt = 0; OUT = 0.
- Single step, repeated 64 times combinationally per cycle:
  - t1 = s66^s93; t2 = s162^s177; t3 = s243^s288; z = t1^t2^t3.
  - t1 ^= (s91&s92)^s171; t2 ^= (s175&s176)^s264; t3 ^= (s286&s287)^s69.
  - Shift: s1..s93 <= t3,s1..s92; s94..s177 <= t1,s94..s176; s178..s288 <= t2,s178..s287.
- Output bit order: z from step 1 of a cycle lands in OUT[63]; z from step 64 lands in OUT[0].
- Every non-reset edge advances the state by 64 steps.
- Init phase:
  - While cnt<18, OUT stays 0 and cnt increments.
  - 18 cycles = 1152 steps; keystream is discarded during this phase.
- Run phase:
  - cnt saturates at 18.
  - OUT <= the 64 z bits computed that cycle.
  - The first keystream block appears in OUT after the 19th rising edge following reset deassertion.
  - A new block appears every cycle thereafter with no gaps.
- Latency: 19 cycles from the first non-reset edge to the first valid OUT; throughput 64 bits per cycle.
- Reset asserted mid-operation (init or run): state reloads, cnt=0, OUT=0 on that edge; init restarts from the beginning.
- Reset held for multiple cycles: state is held at the loaded value, with no stepping.
- No stall input; the generator never pauses outside reset.
- Keystream is periodic only at Trivium's cryptographic period; no wrap logic is required.

Optional Feature:
- Macro: ENCRIPT_PLAINTEXT_XOR_EN.
- Defined: in the run phase OUT <= keystream ^ PLAINTEXT; in the init phase and reset OUT is still 0.
- Undefined: OUT carries raw keystream; the PLAINTEXT parameter is ignored.

Test Plan:
- Reset held 2 cycles, then released -> OUT==64'h0 during reset and for the first 18 post-reset edges; OUT changes on edge 19.
- KEY=0, IV=0: run 50 cycles after reset -> blocks 0..31 match a bit-serial Trivium golden model (1152 steps discarded, MSB-first packing) exactly.
- KEY=80'h80000000000000000000 (K1=1), IV=0 -> compare the first 16 blocks to the golden model; the first block differs from the KEY=0 case.
- Reset asserted for 1 cycle at post-reset cycle 30 -> OUT=0 next edge; the sequence after re-release repeats the original block 0, 1, 2 at cycles 19, 20, 21.
- Reset asserted at cycle 10 (mid-init) -> init restarts; first valid block arrives exactly 19 edges after the second release, equal to the original block 0.
- With ENCRIPT_PLAINTEXT_XOR_EN defined and PLAINTEXT=64'hFFFF_FFFF_FFFF_FFFF -> every run-phase OUT equals the bitwise inverse of the raw keystream; init-phase OUT is still 0.
